// File: rtl/riscv_core_muldiv_wb_queue.sv
// Writeback queue behind the mul/div unit: pairs 64-bit responses with
// in-order {rd, hi} tags and emits a registered 32-bit writeback word.
module riscv_core_muldiv_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tag_val,
  output logic             tag_rdy,
  input  logic [4:0]       tag_rd,
  input  logic             tag_hi,
  input  logic [63:0]      muldivresp_msg_result,
  input  logic             muldivresp_val,
  output logic             muldivresp_rdy,
  output logic             wb_val,
  input  logic             wb_rdy,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [PTR_W:0]   count,
  output logic             proto_err
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [5:0]       tag_mem_q [DEPTH];
  logic [5:0]       tag_mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wb_val_q, wb_val_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             proto_err_q, proto_err_d;

  logic       tag_push;
  logic       resp_go;
  logic       pop;
  logic [5:0] head;

  assign tag_rdy        = (count_q != FULL);
  assign muldivresp_rdy = !wb_val_q || wb_rdy;
  assign resp_go        = muldivresp_val && muldivresp_rdy;
  assign tag_push       = tag_val && tag_rdy;
  assign pop            = resp_go && (count_q != '0);
  assign head           = tag_mem_q[rd_ptr_q];

  always_comb begin
    tag_mem_d   = tag_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wb_val_d    = wb_val_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    proto_err_d = proto_err_q;

    if (tag_push) begin
      tag_mem_d[wr_ptr_q] = {tag_rd, tag_hi};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + (PTR_W+1)'(tag_push) - (PTR_W+1)'(pop);

    if (wb_val_q && wb_rdy) begin
      wb_val_d = 1'b0;
    end
    // Response with no tag is swallowed; flag it permanently.
    if (resp_go && !pop) begin
      proto_err_d = 1'b1;
    end
    if (pop) begin
      wb_val_d  = 1'b1;
      wb_rd_d   = head[5:1];
      wb_data_d = head[0] ? muldivresp_msg_result[63:32]
                          : muldivresp_msg_result[31:0];
    end
  end

  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wb_val_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wb_val_q    <= wb_val_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign wb_val    = wb_val_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign count     = count_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_riscv_core_muldiv_wb_queue.sv
// Bench for riscv_core_muldiv_wb_queue: directed plan steps then random
// traffic, all outputs compared each cycle against a queue-based model.
module tb_riscv_core_muldiv_wb_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             tag_val;
  logic             tag_rdy;
  logic [4:0]       tag_rd;
  logic             tag_hi;
  logic [63:0]      res;
  logic             muldivresp_val;
  logic             muldivresp_rdy;
  logic             wb_val;
  logic             wb_rdy;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [PTR_W:0]   count;
  logic             proto_err;

  riscv_core_muldiv_wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .reset(reset),
    .tag_val(tag_val),
    .tag_rdy(tag_rdy),
    .tag_rd(tag_rd),
    .tag_hi(tag_hi),
    .muldivresp_msg_result(res),
    .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy),
    .wb_val(wb_val),
    .wb_rdy(wb_rdy),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .count(count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tag list plus the word the writeback port should show.
  logic [5:0]  mq[$];
  logic        m_val;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_perr;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("wb_val", 64'(wb_val), 64'(m_val));
    check("wb_rd", 64'(wb_rd), 64'(m_rd));
    check("wb_data", 64'(wb_data), 64'(m_data));
    check("count", 64'(count), 64'(mq.size()));
    check("tag_rdy", 64'(tag_rdy), 64'(mq.size() < DEPTH));
    check("resp_rdy", 64'(muldivresp_rdy), 64'(!m_val || wb_rdy));
    check("proto_err", 64'(proto_err), 64'(m_perr));
  endtask

  // Advance one clock: apply the spec rules to the model, then compare.
  task automatic tick();
    logic go, push, had;
    logic [5:0] h;
    go   = muldivresp_val && (!m_val || wb_rdy);
    push = tag_val && (mq.size() < DEPTH);
    had  = mq.size() > 0;
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_val = 0; m_rd = 0; m_data = 0; m_perr = 0;
    end else begin
      if (m_val && wb_rdy) m_val = 0;
      if (go && had) begin
        h = mq.pop_front();
        m_val  = 1;
        m_rd   = h[5:1];
        m_data = h[0] ? res[63:32] : res[31:0];
      end else if (go) begin
        m_perr = 1;
      end
      if (push) mq.push_back({tag_rd, tag_hi});
    end
    #1;
    check_all();
  endtask

  initial begin
    mq.delete();
    m_val = 0; m_rd = 0; m_data = 0; m_perr = 0;
    reset = 0; tag_val = 1; tag_rd = 5'd3; tag_hi = 0;
    res = 64'h1234; muldivresp_val = 1; wb_rdy = 1;

    tick(); tick();
    reset = 1; tag_val = 0; muldivresp_val = 0;
    tick();
    check("rst_wb_val", 64'(wb_val), 64'd0);
    check("rst_perr", 64'(proto_err), 64'd0);

    // lo/hi select
    tag_val = 1; tag_rd = 5; tag_hi = 0; tick();
    tag_rd = 6; tag_hi = 1; tick();
    tag_val = 0; muldivresp_val = 1; res = 64'h00000002_FFFFFFFE; tick();
    check("lo_rd", 64'(wb_rd), 64'd5);
    check("lo_data", 64'(wb_data), 64'hFFFFFFFE);
    res = 64'h00000003_00000007; tick();
    check("hi_rd", 64'(wb_rd), 64'd6);
    check("hi_data", 64'(wb_data), 64'h3);
    muldivresp_val = 0; tick();

    // full queue
    tag_val = 1;
    for (int i = 0; i < 4; i++) begin
      tag_rd = 5'(20 + i); tag_hi = i[0]; tick();
    end
    check("full_cnt", 64'(count), 64'd4);
    check("full_rdy", 64'(tag_rdy), 64'd0);
    tag_rd = 5'd31; tick();
    check("full_ign", 64'(count), 64'd4);
    tag_val = 0; muldivresp_val = 1; res = 64'hAAAA_5555_0F0F_F0F0; tick();
    check("pop_cnt", 64'(count), 64'd3);
    check("pop_rdy", 64'(tag_rdy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      res = {32'(i), 32'(~i)}; tick();
    end
    muldivresp_val = 0; tick();

    // wrap-around
    for (int i = 1; i <= 10; i++) begin
      tag_val = 1; tag_rd = 5'(i); tag_hi = 0; muldivresp_val = 0; tick();
      tag_val = 0; muldivresp_val = 1; res = 64'(i * 7); tick();
      check("wrap_rd", 64'(wb_rd), 64'(i));
    end
    muldivresp_val = 0; tick();
    check("wrap_cnt", 64'(count), 64'd0);

    // backpressure
    tag_val = 1; tag_rd = 9; tag_hi = 0; tick();
    tag_rd = 10; tag_hi = 1; tick();
    tag_val = 0; muldivresp_val = 1; res = 64'h1111_2222_3333_4444;
    wb_rdy = 0; tick();
    res = 64'h5555_6666_7777_8888;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_rdy", 64'(muldivresp_rdy), 64'd0);
      check("bp_data", 64'(wb_data), 64'h3333_4444);
    end
    wb_rdy = 1; tick();
    check("bp_next_rd", 64'(wb_rd), 64'd10);
    check("bp_next", 64'(wb_data), 64'h5555_6666);
    muldivresp_val = 0; tick();

    // protocol error
    muldivresp_val = 1; res = 64'hDEAD; tick();
    check("perr_set", 64'(proto_err), 64'd1);
    check("perr_nowb", 64'(wb_val), 64'd0);
    muldivresp_val = 0; tag_val = 1; tag_rd = 12; tag_hi = 0; tick();
    tag_val = 0; muldivresp_val = 1; res = 64'h0000_0001_0000_0042; tick();
    check("perr_wb", 64'(wb_data), 64'h42);
    check("perr_stick", 64'(proto_err), 64'd1);
    muldivresp_val = 0; tick();

    // random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(63) != 0);
      tag_val        = $urandom_range(1);
      tag_rd         = 5'($urandom);
      tag_hi         = $urandom_range(1);
      muldivresp_val = ($urandom_range(2) != 0);
      wb_rdy         = ($urandom_range(3) != 0);
      res            = {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_core_muldiv_wb_queue.md
Name: riscv_core_muldiv_wb_queue

Overview:
- Consumer stage directly downstream of the pipelined mul/div unit. It takes that unit's 64-bit response stream and presents a 32-bit writeback stream.
- Holds an in-order tag queue of {rd, hi} pushed by the issue logic when a mul/div request is issued. Each returning 64-bit response is matched to the oldest tag.
- Produces a registered 32-bit writeback word with destination register. Stalls the mul/div unit through muldivresp_rdy when writeback backpressures.

Parameters:
- DEPTH, 4, tag queue entries (power of 2, ≥2); must cover maximum in-flight mul/div ops.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
- tag_val  input  1  issue logic presents a tag.
- tag_rdy  output  1  tag queue can accept (not full).
- tag_rd  input  5  destination register of issued op.
- tag_hi  input  1  1 = select result[63:32] (mulh*/rem*), 0 = result[31:0] (mul/div*).
- muldivresp_msg_result  input  64  result from mul/div unit ({rem,quot} or product).
- muldivresp_val  input  1  response valid.
- muldivresp_rdy  output  1  this block accepts response.
- wb_val  output  1  writeback word valid.
- wb_rdy  input  1  writeback consumer ready.
- wb_rd  output  5  destination register.
- wb_data  output  32  selected result word.
- count  output  PTR_W+1  current tag queue occupancy, 0..DEPTH.
- proto_err  output  1  sticky: response accepted with empty tag queue.

Behaviour:
- Reset (reset==0 at posedge):
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - wb_val = 0, wb_rd = 0, wb_data = 0, proto_err = 0.
  - Tag storage contents are don't-care.
  - Reset mid-operation discards all queued tags and any pending wb word. The next cycle behaves as post-reset.
- Tag queue (circular FIFO):
  - tag_rdy = (count != DEPTH), combinational from registered count.
  - Push: tag_push = tag_val && tag_rdy. Writes {tag_rd, tag_hi} at wr_ptr; wr_ptr increments modulo DEPTH and wraps from DEPTH-1 to 0.
  - Pop: resp_go. Reads the entry at rd_ptr; rd_ptr increments modulo DEPTH.
  - Same-cycle push and pop: count unchanged, both pointers advance.
  - Full: push blocked by tag_rdy=0; a pop in that cycle does not enable a push (no full-bypass).
  - Empty: no same-cycle tag bypass. A tag pushed in cycle N is usable by a response no earlier than cycle N+1.
- Response handshake:
  - muldivresp_rdy = !wb_val || wb_rdy. Combinational, no dependence on muldivresp_val.
  - resp_go = muldivresp_val && muldivresp_rdy.
- Normal response (resp_go with count != 0). Next cycle:
  - wb_val = 1, wb_rd = head.rd.
  - wb_data = head.hi ? result[63:32] : result[31:0].
- Empty-queue response (resp_go with count == 0):
  - Response is consumed and dropped; no wb word is produced.
  - proto_err is set and stays 1 until reset.
  - count does not underflow and pointers do not move.
- Writeback register:
  - If wb_val && wb_rdy && !resp_go: wb_val goes to 0.
  - If wb_val && !wb_rdy: wb_val, wb_rd and wb_data hold unchanged.
  - Back-to-back: resp_go and wb_rdy in the same cycle loads the new word. Sustains 1 word/cycle.
- Latency: response accepted in cycle N gives wb_val=1 in cycle N+1.
- Ordering: strictly in-order; the k-th accepted response pairs with the k-th pushed tag.
- Bubble on stall: wb_val=1, wb_rdy=0 forces muldivresp_rdy=0, which stalls the mul/div pipe. No response is lost or duplicated.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with tag_val=1, muldivresp_val=1 → wb_val=0, count=0, tag_rdy=1, proto_err=0 after release.
- Lo/hi select: push {rd=5,hi=0}, then {rd=6,hi=1}. Return results 0x00000002_FFFFFFFE, then 0x00000003_00000007. Expect wb (5, 0xFFFFFFFE) then (6, 0x00000003), one cycle after each accept.
- Full queue: push 4 tags with no responses → count=4, tag_rdy=0. A 5th push with tag_val=1 is ignored. One response pops (count=3, tag_rdy=1 next cycle).
- Wrap-around: perform 10 push/pop pairs with rd=1..10 → wb_rd sequence is 1..10 in order, count returns to 0, and pointers wrap.
- Backpressure: wb_rdy=0 for 3 cycles while wb_val=1 → muldivresp_rdy=0, wb_data stable. A response held at muldivresp_val=1 is accepted the cycle wb_rdy=1, and its word appears the next cycle.
- Protocol error: muldivresp_val=1 with count=0 → no wb_val, proto_err=1 and sticky. Then push a tag and send a response → normal wb, proto_err remains 1.
